aidc_decomp_sched: RTL and testbench
====================================

# aidc_decomp_sched

Burst scheduler for the AIDC read-decompression datapath. Accepts compressed read bursts from the memory-side R stream, decodes the per-burst mode from the header (first) beat, and dispatches every beat of the burst to one of four decompression channels (ZRL, SR, BPC, RAW bypass). It collects decompressed bursts back from the channels in original arrival order, regardless of per-engine latency, and presents them on a single registered core-side R stream with the original ID.

## Interface
Parameters:
- DATA_W, 256, beat width in bits
- ID_W, 4, AXI ID width
- ORD_DEPTH, 4, order-queue depth, max bursts in flight; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  memory-side beat handshake
- in_data  in  DATA_W  beat payload; on header beat, bits [1:0] = mode (0 ZRL, 1 SR, 2 BPC, 3 RAW)
- in_id  in  ID_W  burst ID, sampled on header beat
- in_last  in  1  last beat of burst
- eng_valid  out  4  per-channel beat valid, one-hot or zero
- eng_ready  in  4  per-channel ready
- eng_data  out  DATA_W  shared dispatch data (= in_data)
- eng_sop / eng_last  out  1  header beat / last beat flags
- ret_valid / ret_ready  in / out  4  per-channel return handshake
- ret_data  in  4*DATA_W  channel c at [c*DATA_W +: DATA_W]
- ret_last  in  4  per-channel return last
- out_valid / out_ready  out / in  1  core-side handshake
- out_data  out  DATA_W
- out_id  out  ID_W
- out_last  out  1
- inflight  out  log2(ORD_DEPTH)+1  bursts queued, not yet fully returned

## Operation
- Dispatch FSM, states HDR and BODY.
- HDR: sel = in_data[1:0]. in_ready = eng_ready[sel] && !ord_full. eng_valid[sel] = in_valid && !ord_full. eng_sop = 1.
- Header handshake:
  - push {sel, in_id} into the order queue;
  - if in_last = 0, latch cur = sel and go to BODY;
  - if in_last = 1 (single-beat burst), stay in HDR.
- BODY: in_ready = eng_ready[cur]; eng_valid[cur] = in_valid; eng_sop = 0; mode bits are ignored. The handshake with in_last = 1 returns the FSM to HDR.
- eng_last = in_last in both states. eng_data = in_data at all times.
- Order queue: ORD_DEPTH-entry circular FIFO of {mode, id}. Wrapping pointers; counter 0..ORD_DEPTH; inflight = counter.
  - Full blocks only header beats. A pop in the same cycle does not unblock a push; the push waits one cycle.
  - Body beats are never blocked by queue state.
- Collector: when the queue is non-empty, head mode h selects channel. ret_ready[h] = skid-buffer space available; all other ret_ready = 0.
  - Accepted return beats carry data, ret_last[h], and head id into the output skid buffer.
  - The accepted beat with ret_last[h] = 1 pops the queue. The next head's channel is eligible in the following cycle.
  - Queue empty: all ret_ready = 0.
- Output: 2-entry skid buffer. out_* are driven from registers only; ret_ready does not depend combinationally on out_ready.
- Reset: FSM→HDR, queue pointers and counter→0, skid buffer emptied. out_valid = 0, out_data/out_id/out_last = 0, inflight = 0, eng_valid = 0, ret_ready = 0. A burst interrupted by reset is abandoned; the engines are reset by the same rst.

## Timing
- Dispatch: combinational. A beat reaches the engine in the same cycle it is accepted; 0-cycle latency, no buffering.
- Return to output: an accepted return beat appears on out_* in the next cycle (1-cycle latency).
- Throughput: 1 beat/cycle on both sides when ready. Burst boundaries on the return side add 0 bubbles.
- Stalls: out_ready low for ≥2 cycles fills the skid buffer; ret_ready drops no later than the cycle after the buffer holds 2 entries. No beat is ever lost or duplicated.
- Simultaneous header push and last-beat pop with count < ORD_DEPTH: count unchanged, both take effect.

## Test plan
- Single 4-beat ZRL burst, id=5, all ready=1: eng_valid = 4'b0001 for 4 cycles with eng_sop on beat 0. ZRL returns 4 beats, which appear on out_* one cycle later with out_id = 5 and out_last on beat 3; inflight goes 1→0.
- Order: SR burst id=1 then BPC burst id=2. The BPC channel returns first. The BPC beats are held (ret_ready[2] = 0) until the SR burst fully drains, so output id order is 1, 2.
- Queue full: 5 single-beat headers with no returns. The first 4 are accepted (inflight = 4), and in_ready = 0 on the 5th. The 5th is accepted in the cycle after the first return last beat is popped.
- Backpressure: out_ready held 0 for 6 cycles during an 8-beat RAW return. Exactly 2 beats are buffered, and all 8 arrive in order once out_ready = 1.
- Engine stall mid-body: eng_ready[1] = 0 for 3 cycles in BODY. in_ready = 0 for those cycles, and no beat goes to any other channel.
- Reset mid-burst (BODY, inflight = 2): after the rst cycle, out_valid = 0, inflight = 0, and the FSM is in HDR. The next header beat is dispatched per its mode.

Source files
------------

// File: rtl/aidc_decomp_sched.sv
// Burst scheduler for the AIDC read-decompression path: dispatches compressed
// bursts to one of four engines and reassembles their returns in arrival order.
module aidc_decomp_sched #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ORD_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ID_W-1:0]            in_id,
    input  logic                       in_last,
    output logic [3:0]                 eng_valid,
    input  logic [3:0]                 eng_ready,
    output logic [DATA_W-1:0]          eng_data,
    output logic                       eng_sop,
    output logic                       eng_last,
    input  logic [3:0]                 ret_valid,
    output logic [3:0]                 ret_ready,
    input  logic [4*DATA_W-1:0]        ret_data,
    input  logic [3:0]                 ret_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_last,
    output logic [$clog2(ORD_DEPTH):0] inflight
);

    localparam int unsigned PTR_W = $clog2(ORD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {HDR, BODY} state_t;

    state_t             state, state_nxt;
    logic [1:0]         cur, cur_nxt;
    logic [1:0]         sel;
    logic               push, pop;

    logic [1:0]         ord_mode [ORD_DEPTH];
    logic [ID_W-1:0]    ord_id   [ORD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   ord_cnt;
    logic               ord_full, ord_empty;

    logic [1:0]         head_mode;
    logic [ID_W-1:0]    head_id;
    logic               acc, acc_last;
    logic [DATA_W-1:0]  acc_data;

    logic               skid_valid, skid_last;
    logic [DATA_W-1:0]  skid_data;
    logic [ID_W-1:0]    skid_id;

    assign sel       = in_data[1:0];
    assign eng_data  = in_data;
    assign eng_last  = in_last;
    assign ord_full  = (ord_cnt == CNT_W'(ORD_DEPTH));
    assign ord_empty = (ord_cnt == '0);
    assign inflight  = ord_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
            cur   <= 2'd0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // Dispatch: header beats steer by their mode bits, body beats follow the latched channel
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        in_ready  = 1'b0;
        eng_valid = 4'b0000;
        eng_sop   = 1'b0;
        push      = 1'b0;
        if (!rst) begin
            case (state)
                HDR: begin
                    eng_sop        = 1'b1;
                    in_ready       = eng_ready[sel] && !ord_full;
                    eng_valid[sel] = in_valid && !ord_full;
                    push           = in_valid && eng_ready[sel] && !ord_full;
                    if (push && !in_last) begin
                        cur_nxt   = sel;
                        state_nxt = BODY;
                    end
                end
                BODY: begin
                    in_ready       = eng_ready[cur];
                    eng_valid[cur] = in_valid;
                    if (in_valid && eng_ready[cur] && in_last) state_nxt = HDR;
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    // Order queue payload: no reset needed, validity is tracked by the counter
    always_ff @(posedge clk) begin
        if (push) begin
            ord_mode[wr_ptr] <= sel;
            ord_id[wr_ptr]   <= in_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ord_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   ord_cnt <= ord_cnt + CNT_W'(1);
                2'b01:   ord_cnt <= ord_cnt - CNT_W'(1);
                default: ord_cnt <= ord_cnt;
            endcase
        end
    end

    assign head_mode = ord_mode[rd_ptr];
    assign head_id   = ord_id[rd_ptr];

    // Collector listens only to the head burst's channel; space = skid slot free
    always_comb begin
        ret_ready = 4'b0000;
        if (!rst && !ord_empty && !skid_valid) ret_ready[head_mode] = 1'b1;
    end

    assign acc      = ret_valid[head_mode] && ret_ready[head_mode];
    assign acc_last = ret_last[head_mode];
    assign acc_data = ret_data[DATA_W*32'(head_mode) +: DATA_W];
    assign pop      = acc && acc_last;

    // Two-entry output buffer: out_* is the head entry, skid_* the overflow entry
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_id    <= '0;
            skid_last  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_id     <= skid_id;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= acc;
                if (acc) begin
                    out_data <= acc_data;
                    out_id   <= head_id;
                    out_last <= acc_last;
                end
            end
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= acc_data;
            skid_id    <= head_id;
            skid_last  <= acc_last;
        end
    end

endmodule

// File: tb/tb_aidc_decomp_sched.sv
// Scoreboard bench for aidc_decomp_sched: expected output beats are queued at
// dispatch time and compared as the core-side stream delivers them.
module tb_aidc_decomp_sched;

    localparam int unsigned DATA_W    = 256;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned ORD_DEPTH = 4;

    logic                clk, rst;
    logic                in_valid, in_ready, in_last;
    logic [DATA_W-1:0]   in_data;
    logic [ID_W-1:0]     in_id;
    logic [3:0]          eng_valid, eng_ready;
    logic [DATA_W-1:0]   eng_data;
    logic                eng_sop, eng_last;
    logic [3:0]          ret_valid, ret_ready, ret_last;
    logic [4*DATA_W-1:0] ret_data;
    logic                out_valid, out_ready, out_last;
    logic [DATA_W-1:0]   out_data;
    logic [ID_W-1:0]     out_id;
    logic [2:0]          inflight;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    aidc_decomp_sched #(.DATA_W(DATA_W), .ID_W(ID_W), .ORD_DEPTH(ORD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_id(in_id), .in_last(in_last),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_data(eng_data), .eng_sop(eng_sop), .eng_last(eng_last),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data), .ret_last(ret_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_last(out_last),
        .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ret_word(input int ch, input int id, input int beat);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < int'(DATA_W / 32); k++)
            w[k*32 +: 32] = (32'h9E37_79B9 * 32'(k + 1)) ^ {8'(ch), 8'(id), 8'(beat), 8'(k)};
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] in_word(input int mode, input int id, input int beat);
        logic [DATA_W-1:0] w;
        w = ret_word(7, id, beat);
        w[1:0] = 2'(mode);
        return w;
    endfunction

    task automatic push_expected(input int ch, input int id, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{ret_word(ch, id, k), ID_W'(id), (k == n - 1)});
    endtask

    // Advance one cycle; a core-side handshake in this cycle is scored against the queue
    task automatic tick();
        beat_t e;
        #1;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got id=%0d last=%0b, required no beat", out_id, out_last);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_id !== e.id || out_last !== e.last) begin
                    errors++;
                    $display("FAIL out_beat: got id=%0d last=%0b data=%h, required id=%0d last=%0b data=%h",
                             out_id, out_last, out_data, e.id, e.last, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input int mode, input int id, input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            in_valid = 1'b1;
            in_data  = (i == 0) ? in_word(mode, id, i) : in_word((mode + 1) % 4, id, i);
            in_id    = ID_W'(id);
            in_last  = (i == n - 1);
            #1;
            while (!in_ready && w < 50) begin
                tick();
                w++;
                #1;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for burst id=%0d beat %0d, required 1", id, i);
            end
            if (i == 0) push_expected(mode, id, n);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic return_burst(input int ch, input int id, input int first, input int n);
        for (int i = first; i < n; i++) begin
            int w = 0;
            ret_valid[ch] = 1'b1;
            ret_data[ch*DATA_W +: DATA_W] = ret_word(ch, id, i);
            ret_last[ch]  = (i == n - 1);
            #1;
            while (!ret_ready[ch] && w < 50) begin
                tick();
                w++;
                #1;
            end
            if (!ret_ready[ch]) begin
                checks++;
                errors++;
                $display("FAIL return_timeout: got ret_ready=0 on ch %0d beat %0d, required 1", ch, i);
            end
            tick();
        end
        ret_valid[ch] = 1'b0;
        ret_last[ch]  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 60) begin
            tick();
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats still expected, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = in_word(2, 1, 0); in_last = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d, required 0", inflight); end
        checks++; if (eng_valid !== 4'b0000) begin errors++; $display("FAIL reset_eng_valid: got %b, required 0000", eng_valid); end
        checks++; if (ret_ready !== 4'b0000) begin errors++; $display("FAIL reset_ret_ready: got %b, required 0000", ret_ready); end
        checks++; if (out_data !== '0 || out_id !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_out_regs: got id=%0d last=%0b, required zeros", out_id, out_last); end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        tick();
    endtask

    task automatic test_zrl_burst();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = in_word(0, 5, i); in_id = 4'd5; in_last = (i == 3);
            #1;
            checks++; if (eng_valid !== 4'b0001) begin errors++; $display("FAIL zrl_eng_valid: got %b, required 0001", eng_valid); end
            checks++; if (eng_sop !== (i == 0) || in_ready !== 1'b1) begin errors++; $display("FAIL zrl_sop_ready: got sop=%0b ready=%0b, required sop=%0b ready=1", eng_sop, in_ready, (i == 0)); end
            checks++; if (eng_data !== in_data || eng_last !== in_last) begin errors++; $display("FAIL zrl_eng_data: got last=%0b, required last=%0b with passthrough data", eng_last, in_last); end
            if (i == 0) push_expected(0, 5, 4);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL zrl_inflight_1: got %0d, required 1", inflight); end
        for (int i = 0; i < 4; i++) begin
            ret_valid[0] = 1'b1; ret_data[0 +: DATA_W] = ret_word(0, 5, i); ret_last[0] = (i == 3);
            #1;
            checks++; if (ret_ready !== 4'b0001) begin errors++; $display("FAIL zrl_ret_ready: got %b, required 0001", ret_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== ret_word(0, 5, i)) begin errors++; $display("FAIL zrl_latency: got out_valid=%0b at beat %0d, required 1 with matching data", out_valid, i); end
        end
        ret_valid[0] = 1'b0; ret_last[0] = 1'b0;
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL zrl_inflight_0: got %0d, required 0", inflight); end
        drain();
    endtask

    task automatic test_order();
        send_burst(1, 1, 2);
        send_burst(2, 2, 2);
        checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL order_inflight: got %0d, required 2", inflight); end
        ret_valid[2] = 1'b1; ret_data[2*DATA_W +: DATA_W] = ret_word(2, 2, 0); ret_last[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ret_ready !== 4'b0010) begin errors++; $display("FAIL order_hold: got ret_ready=%b, required 0010", ret_ready); end
            tick();
        end
        return_burst(1, 1, 0, 2);
        return_burst(2, 2, 0, 2);
        drain();
    endtask

    task automatic test_queue_full();
        for (int k = 0; k < 4; k++) send_burst(3, 8 + k, 1);
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight: got %0d, required 4", inflight); end
        in_valid = 1'b1; in_data = in_word(3, 12, 0); in_id = 4'd12; in_last = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || eng_valid !== 4'b0000) begin errors++; $display("FAIL full_block: got in_ready=%0b eng_valid=%b, required 0 and 0000", in_ready, eng_valid); end
            tick();
        end
        ret_valid[3] = 1'b1; ret_data[3*DATA_W +: DATA_W] = ret_word(3, 8, 0); ret_last[3] = 1'b1;
        #1;
        checks++; if (ret_ready !== 4'b1000 || in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_cycle: got ret_ready=%b in_ready=%0b, required 1000 and 0", ret_ready, in_ready); end
        tick();
        ret_valid[3] = 1'b0; ret_last[3] = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || inflight !== 3'd3) begin errors++; $display("FAIL full_unblock: got in_ready=%0b inflight=%0d, required 1 and 3", in_ready, inflight); end
        push_expected(3, 12, 1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d, required 4", inflight); end
        for (int k = 1; k < 5; k++) return_burst(3, 8 + k, 0, 1);
        drain();
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d, required 0", inflight); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        send_burst(3, 6, 8);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ret_valid[3] = 1'b1; ret_data[3*DATA_W +: DATA_W] = ret_word(3, 6, acc); ret_last[3] = 1'b0;
            #1;
            if (ret_ready[3]) acc++;
            tick();
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL bp_buffered: got %0d beats accepted, required 2", acc); end
        checks++; if (ret_ready !== 4'b0000 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall: got ret_ready=%b out_valid=%0b, required 0000 and 1", ret_ready, out_valid); end
        out_ready = 1'b1;
        return_burst(3, 6, acc, 8);
        drain();
    endtask

    task automatic test_eng_stall();
        in_valid = 1'b1; in_data = in_word(1, 3, 0); in_id = 4'd3; in_last = 1'b0;
        push_expected(1, 3, 4);
        tick();
        in_data = in_word(2, 3, 1);
        eng_ready = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || eng_valid !== 4'b0010) begin errors++; $display("FAIL stall_body: got in_ready=%0b eng_valid=%b, required 0 and 0010", in_ready, eng_valid); end
            tick();
        end
        eng_ready = 4'b1111;
        #1;
        checks++; if (in_ready !== 1'b1 || eng_sop !== 1'b0 || eng_valid !== 4'b0010) begin errors++; $display("FAIL stall_resume: got in_ready=%0b sop=%0b eng_valid=%b, required 1, 0, 0010", in_ready, eng_sop, eng_valid); end
        tick();
        for (int i = 2; i < 4; i++) begin
            in_data = in_word(0, 3, i); in_last = (i == 3);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        return_burst(1, 3, 0, 4);
        drain();
    endtask

    task automatic test_reset_mid();
        send_burst(3, 9, 1);
        in_valid = 1'b1; in_data = in_word(0, 10, 0); in_id = 4'd10; in_last = 1'b0;
        push_expected(0, 10, 4);
        tick();
        in_data = in_word(1, 10, 1);
        tick();
        checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL mid_inflight: got %0d, required 2", inflight); end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checks++; if (out_valid !== 1'b0 || inflight !== 3'd0) begin errors++; $display("FAIL mid_reset: got out_valid=%0b inflight=%0d, required 0 and 0", out_valid, inflight); end
        in_valid = 1'b1; in_data = in_word(2, 4, 0); in_id = 4'd4; in_last = 1'b1;
        #1;
        checks++; if (eng_valid !== 4'b0100 || eng_sop !== 1'b1) begin errors++; $display("FAIL mid_hdr: got eng_valid=%b sop=%0b, required 0100 and 1", eng_valid, eng_sop); end
        push_expected(2, 4, 1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        return_burst(2, 4, 0, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        int b0 = 0;
        int b1 = 0;
        send_burst(0, 1, 2);
        send_burst(1, 2, 2);
        for (int c = 0; c < 4; c++) begin
            ret_valid[0] = (b0 < 2); ret_data[0 +: DATA_W] = ret_word(0, 1, b0); ret_last[0] = (b0 == 1);
            ret_valid[1] = (b1 < 2); ret_data[DATA_W +: DATA_W] = ret_word(1, 2, b1); ret_last[1] = (b1 == 1);
            #1;
            if (ret_ready[0] && ret_valid[0]) b0++;
            if (ret_ready[1] && ret_valid[1]) b1++;
            tick();
            checks++; if (b0 + b1 != c + 1 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_rate: got %0d beats after %0d cycles out_valid=%0b, required %0d and 1", b0 + b1, c + 1, out_valid, c + 1); end
        end
        ret_valid = 4'b0000; ret_last = 4'b0000;
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_id = '0; in_last = 1'b0;
        eng_ready = 4'b1111; ret_valid = 4'b0000; ret_data = '0; ret_last = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_zrl_burst();
        test_order();
        test_queue_full();
        test_backpressure();
        test_eng_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
